multicycle_cpu: RTL and testbench

//  Parametrised multi-cycle successor of the single-cycle CPU core. Executes the

---
 rtl/multicycle_cpu.sv | 257 +++++++++++++++++++++++++
 tb/tb_multicycle_cpu.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU core: FETCH/DECODE/EXEC/MEM/WB sequencer with req/ack instruction
// and data ports, an internal register file and registered bus outputs.
module multicycle_cpu #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned INSN_ADDR_WIDTH = 32,
  parameter int unsigned DATA_ADDR_WIDTH = 32,
  parameter int unsigned REG_NUM_WIDTH   = 5,
  parameter int unsigned RESET_PC        = 0,
  parameter int unsigned PC_INC          = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [INSN_ADDR_WIDTH-1:0] insnAddr,
  output logic                       insnReq,
  input  logic                       insnAck,
  input  logic [31:0]                insn,
  output logic [DATA_ADDR_WIDTH-1:0] dataAddr,
  output logic [DATA_WIDTH-1:0]      dataOut,
  output logic                       dataWrEnable,
  output logic                       dataReq,
  input  logic                       dataAck,
  input  logic [DATA_WIDTH-1:0]      dataIn,
  output logic                       retire,
  output logic                       illegalInsn
);

  localparam int unsigned REG_COUNT = 2 ** REG_NUM_WIDTH;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LD    = 6'h23;
  localparam logic [5:0] OP_ST    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} stateT;

  stateT state;
  stateT stateNext;

  logic [INSN_ADDR_WIDTH-1:0] pc;
  logic [31:0]                ir;
  logic [DATA_WIDTH-1:0]      aReg;
  logic [DATA_WIDTH-1:0]      bReg;
  logic [DATA_WIDTH-1:0]      kReg;
  logic [DATA_WIDTH-1:0]      aluReg;
  logic [DATA_WIDTH-1:0]      memReg;
  logic                       takenReg;
  logic [DATA_WIDTH-1:0]      regs [REG_COUNT];

  logic [5:0]               op;
  logic [5:0]               funct;
  logic [4:0]               shamt;
  logic [REG_NUM_WIDTH-1:0] rsIdx;
  logic [REG_NUM_WIDTH-1:0] rtIdx;
  logic [REG_NUM_WIDTH-1:0] rdIdx;

  logic [DATA_WIDTH-1:0]      aluResult;
  logic [REG_NUM_WIDTH-1:0]   dstIdx;
  logic                       legal;
  logic                       writeEn;
  logic                       isLoad;
  logic                       isStore;
  logic                       branchTaken;
  logic                       bigShift;
  logic [INSN_ADDR_WIDTH-1:0] pcPlus;
  logic [INSN_ADDR_WIDTH-1:0] pcBranch;

  logic insnReqNext;
  logic dataReqNext;
  logic dataWrNext;
  logic retireNext;
  logic illegalNext;
  logic fetchDone;
  logic memDone;

  assign op       = ir[31:26];
  assign funct    = ir[5:0];
  assign shamt    = ir[10:6];
  assign rsIdx    = REG_NUM_WIDTH'(ir[25:21]);
  assign rtIdx    = REG_NUM_WIDTH'(ir[20:16]);
  assign rdIdx    = REG_NUM_WIDTH'(ir[15:11]);
  assign bigShift = 32'(shamt) >= DATA_WIDTH;
  assign insnAddr = pc;

  // Handshakes only count while our own request is up.
  assign fetchDone = insnReq & insnAck;
  assign memDone   = dataReq & dataAck;

  assign pcPlus   = pc + INSN_ADDR_WIDTH'(PC_INC);
  assign pcBranch = pcPlus + (INSN_ADDR_WIDTH'($signed(ir[15:0])) << 2);

  // Instruction decode and ALU; operands are stable from EXEC onward.
  always_comb begin
    aluResult   = '0;
    dstIdx      = rsIdx;
    legal       = 1'b0;
    writeEn     = 1'b0;
    isLoad      = 1'b0;
    isStore     = 1'b0;
    branchTaken = 1'b0;
    case (op)
      OP_RTYPE: begin
        legal   = 1'b1;
        writeEn = 1'b1;
        dstIdx  = rdIdx;
        case (funct)
          FN_ADD: aluResult = aReg + bReg;
          FN_SUB: aluResult = aReg - bReg;
          FN_AND: aluResult = aReg & bReg;
          FN_OR:  aluResult = aReg | bReg;
          FN_SLT: aluResult = DATA_WIDTH'($signed(aReg) < $signed(bReg));
          FN_SLL: begin
            dstIdx    = rsIdx;
            aluResult = bigShift ? '0 : (bReg << shamt);
          end
          FN_SRL: begin
            dstIdx    = rsIdx;
            aluResult = bigShift ? '0 : (bReg >> shamt);
          end
          default: begin
            legal   = 1'b0;
            writeEn = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        legal     = 1'b1;
        writeEn   = 1'b1;
        aluResult = bReg + kReg;
      end
      OP_ANDI: begin
        legal     = 1'b1;
        writeEn   = 1'b1;
        aluResult = bReg & kReg;
      end
      OP_ORI: begin
        legal     = 1'b1;
        writeEn   = 1'b1;
        aluResult = bReg | kReg;
      end
      OP_LD: begin
        legal     = 1'b1;
        writeEn   = 1'b1;
        isLoad    = 1'b1;
        aluResult = bReg + kReg;
      end
      OP_ST: begin
        legal     = 1'b1;
        isStore   = 1'b1;
        aluResult = bReg + kReg;
      end
      OP_BEQ: begin
        legal       = 1'b1;
        branchTaken = (aReg == bReg);
      end
      OP_BNE: begin
        legal       = 1'b1;
        branchTaken = (aReg != bReg);
      end
      default: legal = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= stateNext;
  end

  // Next state and next values of the registered bus outputs.
  always_comb begin
    stateNext = state;
    case (state)
      FETCH:   if (fetchDone) stateNext = DECODE;
      DECODE:  stateNext = EXEC;
      EXEC:    stateNext = (isLoad || isStore) ? MEM : WB;
      MEM:     if (memDone) stateNext = WB;
      WB:      stateNext = FETCH;
      default: stateNext = FETCH;
    endcase
    insnReqNext = (stateNext == FETCH);
    dataReqNext = (stateNext == MEM);
    dataWrNext  = (stateNext == MEM) && isStore;
    retireNext  = (stateNext == WB);
    illegalNext = (stateNext == WB) && !legal;
  end

  // Bus outputs; address and store data are captured once on entry to MEM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      insnReq      <= 1'b0;
      dataReq      <= 1'b0;
      dataWrEnable <= 1'b0;
      dataAddr     <= '0;
      dataOut      <= '0;
      retire       <= 1'b0;
      illegalInsn  <= 1'b0;
    end else begin
      insnReq      <= insnReqNext;
      dataReq      <= dataReqNext;
      dataWrEnable <= dataWrNext;
      retire       <= retireNext;
      illegalInsn  <= illegalNext;
      if (state == EXEC && stateNext == MEM) begin
        dataAddr <= DATA_ADDR_WIDTH'(aluResult);
        dataOut  <= aReg;
      end
    end
  end

  // Datapath registers, register file and PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= INSN_ADDR_WIDTH'(RESET_PC);
      ir       <= '0;
      aReg     <= '0;
      bReg     <= '0;
      kReg     <= '0;
      aluReg   <= '0;
      memReg   <= '0;
      takenReg <= 1'b0;
      for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: if (fetchDone) ir <= insn;
        DECODE: begin
          aReg <= regs[rsIdx];
          bReg <= regs[rtIdx];
          kReg <= DATA_WIDTH'($signed(ir[15:0]));
        end
        EXEC: begin
          aluReg   <= aluResult;
          takenReg <= branchTaken;
        end
        MEM: if (memDone && isLoad) memReg <= dataIn;
        WB: begin
          // r0 is never written, so it always reads back as zero.
          if (writeEn && dstIdx != '0) regs[dstIdx] <= isLoad ? memReg : aluReg;
          pc <= takenReg ? pcBranch : pcPlus;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed testbench for multicycle_cpu: drives instructions and memory acks,
// observes register contents through stores on the data port.
module tb_multicycle_cpu;

  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LD   = 6'h23;
  localparam logic [5:0] OP_ST   = 6'h2B;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] insnAddr;
  logic        insnReq;
  logic        insnAck = 1'b0;
  logic [31:0] insn = '0;
  logic [31:0] dataAddr;
  logic [31:0] dataOut;
  logic        dataWrEnable;
  logic        dataReq;
  logic        dataAck = 1'b0;
  logic [31:0] dataIn = '0;
  logic        retire;
  logic        illegalInsn;

  int nChecks = 0;
  int nPass   = 0;

  logic [31:0] expPc;
  int          obsWait;
  int          obsCycles;
  int          dCyc;
  logic        unstable;
  logic [31:0] obsAddr;
  logic [31:0] obsData;
  logic        obsWe;
  logic        obsIllegal;

  multicycle_cpu dut (
    .clk          (clk),
    .rst          (rst),
    .insnAddr     (insnAddr),
    .insnReq      (insnReq),
    .insnAck      (insnAck),
    .insn         (insn),
    .dataAddr     (dataAddr),
    .dataOut      (dataOut),
    .dataWrEnable (dataWrEnable),
    .dataReq      (dataReq),
    .dataAck      (dataAck),
    .dataIn       (dataIn),
    .retire       (retire),
    .illegalInsn  (illegalInsn)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] iT(input logic [5:0] op, input int rs, input int rt, input int k);
    return {op, 5'(rs), 5'(rt), 16'(k)};
  endfunction

  function automatic logic [31:0] rT(input int rs, input int rt, input int rd, input int sh,
                                     input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Fetch one instruction at expPc, serve its data access, run until retire.
  task automatic runInsn(input string tag, input logic [31:0] word, input int ackDelay,
                         input logic [31:0] ldData);
    int w = 0;
    int cyc;
    while (!insnReq && w < 20) begin
      @(negedge clk);
      w++;
    end
    obsWait = w;
    check({tag, " pc"}, 64'(insnAddr), 64'(expPc));
    insn    = word;
    insnAck = 1'b1;
    @(negedge clk);
    insnAck  = 1'b0;
    cyc      = 2;
    dCyc     = 0;
    unstable = 1'b0;
    while (!retire && cyc < 40) begin
      dataAck = 1'b0;
      if (dataReq) begin
        dCyc++;
        if (dCyc == 1) begin
          obsAddr = dataAddr;
          obsData = dataOut;
          obsWe   = dataWrEnable;
        end else if (dataAddr !== obsAddr || dataOut !== obsData || dataWrEnable !== obsWe) begin
          unstable = 1'b1;
        end
        if (dCyc > ackDelay) begin
          dataAck = 1'b1;
          dataIn  = ldData;
        end
      end
      @(negedge clk);
      cyc++;
    end
    dataAck    = 1'b0;
    obsCycles  = cyc;
    obsIllegal = illegalInsn;
    expPc      = expPc + 32'd4;
  endtask

  // Read a register back by storing it to address 0x40.
  task automatic storeCheck(input string tag, input int r, input logic [31:0] exp);
    runInsn(tag, iT(OP_ST, r, 0, 'h40), 0, '0);
    check({tag, " value"}, 64'(obsData), 64'(exp));
  endtask

  initial begin
    int w;
    expPc = 32'h0;
    // Reset state
    insnAck = 1'b1;
    insn    = iT(OP_ADDI, 1, 0, 5);
    repeat (3) @(negedge clk);
    check("reset insnReq", 64'(insnReq), 64'(0));
    check("reset dataReq", 64'(dataReq), 64'(0));
    check("reset dataAddr/Out", 64'({dataAddr, dataOut}), 64'(0));
    check("reset flags", 64'({dataWrEnable, retire, illegalInsn}), 64'(0));
    rst = 1'b0;

    // 1: ADDI with insnAck tied high across reset release
    runInsn("addi", iT(OP_ADDI, 1, 0, 5), 0, '0);
    check("insnReq first cycle", 64'(obsWait), 64'(1));
    check("addi latency", 64'(obsCycles), 64'(4));
    check("addi illegal", 64'(obsIllegal), 64'(0));
    storeCheck("st r1", 1, 32'd5);
    check("st latency", 64'(obsCycles), 64'(5));
    check("st we", 64'(obsWe), 64'(1));
    check("st addr", 64'(obsAddr), 64'(32'h40));

    // 2: ALU patterns
    runInsn("ld r1", iT(OP_LD, 1, 0, 0), 0, 32'h7FFF_FFFF);
    check("ld we", 64'(obsWe), 64'(0));
    check("ld latency", 64'(obsCycles), 64'(5));
    runInsn("addi r2", iT(OP_ADDI, 2, 0, 1), 0, '0);
    runInsn("add r3", rT(1, 2, 3, 0, FN_ADD), 0, '0);
    runInsn("slt r4", rT(3, 1, 4, 0, FN_SLT), 0, '0);
    runInsn("sub r6", rT(2, 1, 6, 0, FN_SUB), 0, '0);
    runInsn("sll r7", rT(7, 1, 0, 4, FN_SLL), 0, '0);
    runInsn("srl r8", rT(8, 3, 0, 31, FN_SRL), 0, '0);
    runInsn("ori r9", iT(OP_ORI, 9, 2, 'hF000), 0, '0);
    runInsn("andi r10", iT(OP_ANDI, 10, 1, 'h8001), 0, '0);
    runInsn("or r11", rT(3, 2, 11, 0, FN_OR), 0, '0);
    runInsn("and r12", rT(9, 7, 12, 0, FN_AND), 0, '0);
    storeCheck("r3 add", 3, 32'h8000_0000);
    storeCheck("r4 slt", 4, 32'h1);
    storeCheck("r6 sub", 6, 32'h8000_0002);
    storeCheck("r7 sll", 7, 32'hFFFF_FFF0);
    storeCheck("r8 srl", 8, 32'h1);
    storeCheck("r9 ori", 9, 32'hFFFF_F001);
    storeCheck("r10 andi", 10, 32'h7FFF_8001);
    storeCheck("r11 or", 11, 32'h8000_0001);
    storeCheck("r12 and", 12, 32'hFFFF_F000);

    // 3: delayed data ack
    runInsn("addi r2", iT(OP_ADDI, 2, 0, 'h100), 0, '0);
    runInsn("st slow", iT(OP_ST, 1, 2, 8), 3, '0);
    check("st slow req cycles", 64'(dCyc), 64'(4));
    check("st slow stable", 64'(unstable), 64'(0));
    check("st slow addr", 64'(obsAddr), 64'(32'h108));
    check("st slow data", 64'(obsData), 64'(32'h7FFF_FFFF));
    runInsn("ld slow", iT(OP_LD, 5, 2, 8), 3, 32'h7FFF_FFFF);
    check("ld slow latency", 64'(obsCycles), 64'(8));
    check("ld slow addr", 64'(obsAddr), 64'(32'h108));
    check("ld slow we", 64'(obsWe), 64'(0));
    storeCheck("r5 loaded", 5, 32'h7FFF_FFFF);
    runInsn("ld negk", iT(OP_LD, 13, 2, -4), 0, 32'h1234_5678);
    check("ld negk addr", 64'(obsAddr), 64'(32'hFC));
    storeCheck("r13 loaded", 13, 32'h1234_5678);

    // 6: undefined op/funct and r0 writes
    runInsn("op 3f", iT(6'h3F, 1, 1, 'h1234), 0, '0);
    check("op 3f illegal", 64'(obsIllegal), 64'(1));
    check("op 3f latency", 64'(obsCycles), 64'(4));
    runInsn("fn 3f", rT(1, 1, 1, 0, 6'h3F), 0, '0);
    check("fn 3f illegal", 64'(obsIllegal), 64'(1));
    storeCheck("r1 untouched", 1, 32'h7FFF_FFFF);
    runInsn("addi r0", iT(OP_ADDI, 0, 0, 7), 0, '0);
    storeCheck("r0 zero", 0, 32'h0);

    // 5: reset during a store that is still waiting for ack
    w = 0;
    while (!insnReq && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("rst st pc", 64'(insnAddr), 64'(expPc));
    insn    = iT(OP_ST, 1, 0, 'h20);
    insnAck = 1'b1;
    @(negedge clk);
    insnAck = 1'b0;
    w = 0;
    while (!dataReq && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("rst st reached mem", 64'(dataReq), 64'(1));
    rst = 1'b1;
    #1;
    check("rst drops dataReq", 64'(dataReq), 64'(0));
    check("rst drops we/insnReq", 64'({dataWrEnable, insnReq}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
    expPc = 32'h0;
    storeCheck("r1 cleared", 1, 32'h0);
    storeCheck("r3 cleared", 3, 32'h0);
    storeCheck("r5 cleared", 5, 32'h0);
    storeCheck("r12 cleared", 12, 32'h0);

    // 4: branches from PC 0x10
    runInsn("beq eq", iT(OP_BEQ, 1, 2, -2), 0, '0);
    check("beq latency", 64'(obsCycles), 64'(4));
    expPc = 32'h0C;
    runInsn("addi r1", iT(OP_ADDI, 1, 0, 3), 0, '0);
    runInsn("beq ne", iT(OP_BEQ, 1, 2, -2), 0, '0);
    runInsn("bne ne", iT(OP_BNE, 1, 2, -2), 0, '0);
    expPc = 32'h10;
    runInsn("bne eq", iT(OP_BNE, 2, 0, -2), 0, '0);
    runInsn("after bne", iT(OP_ADDI, 0, 0, 0), 0, '0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
